// File: rtl/mp64_extmem_model.sv
// mp64_extmem_model: parametrised external-memory responder for the phy_* port.
// Define MP64_EXTMEM_REFRESH_EN to compile in periodic refresh stalls.
module mp64_extmem_model #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 32768,
  parameter int RD_LAT    = 1,
  parameter int WR_LAT    = 1,
  parameter int BURST_W   = 4,
  parameter int REF_INTVL = 1024,
  parameter int REF_CYC   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              phy_req,
  input  logic [ADDR_W-1:0] phy_addr,
  input  logic              phy_wen,
  input  logic [BURST_W-1:0] phy_burst_len,
  input  logic [DATA_W-1:0] phy_wdata,
  output logic              phy_wready,
  output logic [DATA_W-1:0] phy_rdata,
  output logic              phy_rvalid,
  output logic              phy_ready,
  output logic              phy_err_oor,
  output logic              refresh_busy
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [3:0] RL = 4'(RD_LAT);
  localparam logic [3:0] WL = 4'(WR_LAT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RD_BEAT = 3'd2;
  localparam logic [2:0] S_WR_WAIT = 3'd3;
  localparam logic [2:0] S_WR_BEAT = 3'd4;
`ifdef MP64_EXTMEM_REFRESH_EN
  localparam logic [2:0] S_REFRESH = 3'd5;
`endif

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [2:0]         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [BURST_W-1:0] r_left;
  logic [3:0]         r_wait;
  logic               r_ready;
  logic               r_rvalid;
  logic               r_wready;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;

  logic [ADDR_W-1:0]  w_word;
  logic [IDX_W-1:0]   w_idx;
  logic               w_hi;
  logic               w_accept;
  logic               w_last;
  logic               w_wrap;
  logic               w_mem_we;

  assign w_word   = phy_addr >> OFF_W;
  assign w_idx    = w_word[IDX_W-1:0];
  assign w_hi     = (w_word >> IDX_W) != '0;
  assign w_accept = phy_req && phy_ready;
  assign w_last   = r_left == '0;
  // Next beat would step past the top word and wrap to 0.
  assign w_wrap   = r_idx == {IDX_W{1'b1}};
  assign w_mem_we = (r_state == S_WR_BEAT) && r_wready;

`ifdef MP64_EXTMEM_REFRESH_EN
  localparam int RC_W = $clog2(REF_INTVL + 1);
  localparam int CY_W = $clog2(REF_CYC + 1);

  logic [RC_W-1:0] r_ref_cnt;
  logic            r_ref_pend;
  logic [CY_W-1:0] r_ref_left;
  logic            r_busy;
  logic            w_ref_tick;

  assign w_ref_tick   = r_ref_cnt == RC_W'(REF_INTVL - 1);
  assign phy_ready    = r_ready & ~r_ref_pend;
  assign refresh_busy = r_busy;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ref_cnt <= '0;
    end else if (w_ref_tick) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_unused     = (REF_INTVL > 0) ^ (REF_CYC > 0);
  assign phy_ready    = r_ready;
  assign refresh_busy = 1'b0;
`endif

  assign phy_wready  = r_wready;
  assign phy_rvalid  = r_rvalid;
  assign phy_rdata   = r_rdata;
  assign phy_err_oor = r_err;

  always_ff @(posedge sys_clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= phy_wdata;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_left   <= '0;
      r_wait   <= '0;
      r_ready  <= 1'b1;
      r_rvalid <= 1'b0;
      r_wready <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
`ifdef MP64_EXTMEM_REFRESH_EN
      r_ref_pend <= 1'b0;
      r_ref_left <= '0;
      r_busy     <= 1'b0;
`endif
    end else begin
      r_rvalid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
`ifdef MP64_EXTMEM_REFRESH_EN
          if (r_ref_pend) begin
            r_state    <= S_REFRESH;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_ref_pend <= 1'b0;
            r_ref_left <= CY_W'(REF_CYC - 1);
          end else
`endif
          if (w_accept) begin
            r_idx   <= w_idx;
            r_left  <= phy_burst_len;
            r_ready <= 1'b0;
            if (w_hi) r_err <= 1'b1;
            if (phy_wen) begin
              r_wait  <= WL;
              r_state <= (WL == '0) ? S_WR_BEAT
                                    : S_WR_WAIT;
            end else begin
              r_wait  <= RL;
              r_state <= (RL == '0) ? S_RD_BEAT
                                    : S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_wait <= 4'd1) r_state <= S_RD_BEAT;
          else r_wait <= r_wait - 1'b1;
        end
        S_RD_BEAT: begin
          r_rvalid <= 1'b1;
          r_rdata  <= r_mem[r_idx];
          r_idx    <= r_idx + 1'b1;
          if (w_last) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_left <= r_left - 1'b1;
            if (w_wrap) r_err <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (r_wait <= 4'd1) r_state <= S_WR_BEAT;
          else r_wait <= r_wait - 1'b1;
        end
        S_WR_BEAT: begin
          // First cycle here only raises wready; beats land after.
          if (!r_wready) begin
            r_wready <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
              r_wready <= 1'b0;
              r_ready  <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_left <= r_left - 1'b1;
              if (w_wrap) r_err <= 1'b1;
            end
          end
        end
`ifdef MP64_EXTMEM_REFRESH_EN
        S_REFRESH: begin
          if (r_ref_left == '0) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_ref_left <= r_ref_left - 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
`ifdef MP64_EXTMEM_REFRESH_EN
      if (w_ref_tick) r_ref_pend <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mp64_extmem_model.sv
// Directed bench for mp64_extmem_model: reads, write bursts, back-to-back,
// wrap/oor, reset mid-burst and (MP64_EXTMEM_REFRESH_EN) refresh stalls.
module tb_mp64_extmem_model;

`ifdef MP64_EXTMEM_REFRESH_EN
  localparam int B_RI = 16;
  localparam int B_RC = 4;
`else
  localparam int B_RI = 1024;
  localparam int B_RC = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  blen = '0;
  logic [63:0] wdata = '0;

  logic        a_wrdy, a_rv, a_rdy, a_err, a_busy;
  logic        b_wrdy, b_rv, b_rdy, b_err, b_busy;
  logic [63:0] a_rdata, b_rdata;

  logic        wrdy, rv, rdy, err, busy;
  logic [63:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] got [16];
  int nb, first, last, wfirst, wlast;
  logic rdy1, rdy_last, post_wrdy, post_rdy;
  int nbusy, busy_beat, busy_rdy;

  always #5 clk = ~clk;

  assign wrdy  = sel ? b_wrdy  : a_wrdy;
  assign rv    = sel ? b_rv    : a_rv;
  assign rdy   = sel ? b_rdy   : a_rdy;
  assign err   = sel ? b_err   : a_err;
  assign busy  = sel ? b_busy  : a_busy;
  assign rdata = sel ? b_rdata : a_rdata;

  mp64_extmem_model u_a (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .phy_req(req & ~sel), .phy_addr(addr),
    .phy_wen(wen), .phy_burst_len(blen),
    .phy_wdata(wdata), .phy_wready(a_wrdy),
    .phy_rdata(a_rdata), .phy_rvalid(a_rv),
    .phy_ready(a_rdy), .phy_err_oor(a_err),
    .refresh_busy(a_busy)
  );

  mp64_extmem_model #(
    .RD_LAT(0), .WR_LAT(0),
    .REF_INTVL(B_RI), .REF_CYC(B_RC)
  ) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .phy_req(req & sel), .phy_addr(addr),
    .phy_wen(wen), .phy_burst_len(blen),
    .phy_wdata(wdata), .phy_wready(b_wrdy),
    .phy_rdata(b_rdata), .phy_rvalid(b_rv),
    .phy_ready(b_rdy), .phy_err_oor(b_err),
    .refresh_busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!rdy && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, rdy}, 64'd1);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [3:0] l,
                    input logic [63:0] base);
    int k = 0;
    wait_ready("wr_ready");
    req = 1'b1; addr = a; wen = 1'b1; blen = l;
    tick();
    req = 1'b0;
    wfirst = -1;
    for (int i = 0; i <= int'(l); i++) begin
      int n = 0;
      while (!wrdy && n < 40) begin
        tick(); k++; n++;
      end
      if (!wrdy) begin
        chk("wr_wready_timeout", 64'd0, 64'd1);
        break;
      end
      if (i == 0) wfirst = k;
      wlast = k;
      wdata = base + 64'(i);
      tick(); k++;
    end
    post_wrdy = wrdy;
    post_rdy  = rdy;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [3:0] l);
    logic bdone = 1'b0;
    wait_ready("rd_ready");
    req = 1'b1; addr = a; wen = 1'b0; blen = l;
    tick();
    req = 1'b0;
    nb = 0; first = -1; last = -1;
    nbusy = 0; busy_beat = 0; busy_rdy = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) rdy1 = rdy;
      if (rv) begin
        if (nb < 16) got[nb] = rdata;
        if (nb == 0) first = k;
        last = k;
        rdy_last = rdy;
        nb++;
      end
      if (busy && nb > 0 && nb <= int'(l)) busy_beat++;
      if (busy && !bdone) begin
        nbusy++;
        if (rdy) busy_rdy++;
      end
      if (!busy && nbusy > 0) bdone = 1'b1;
    end
  endtask

  initial begin
    logic [8:0]  hist;
    logic [63:0] bd [9];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  {63'd0, a_rdy},  64'd1);
    chk("rst_rvalid", {63'd0, a_rv},   64'd0);
    chk("rst_wready", {63'd0, a_wrdy}, 64'd0);
    chk("rst_rdata",  a_rdata,         64'd0);
    chk("rst_err",    {63'd0, a_err},  64'd0);
    chk("rst_busy",   {63'd0, a_busy}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single read, RD_LAT=1
    wr(32'h10, 4'd0, 64'hDEADBEEF_CAFEF00D);
    rd(32'h10, 4'd0);
    chk("rd1_beats",   64'(nb), 64'd1);
    chk("rd1_first",   64'(first), 64'd2);
    chk("rd1_rdy_t1",  {63'd0, rdy1}, 64'd0);
    chk("rd1_rdy_t2",  {63'd0, rdy_last}, 64'd1);
    chk("rd1_data",    got[0], 64'hDEADBEEF_CAFEF00D);

    // Write burst then read back
    wr(32'h100, 4'd3, 64'd1);
    chk("wr_first",    64'(wfirst), 64'd2);
    chk("wr_span",     64'(wlast - wfirst), 64'd3);
    chk("wr_post_wrdy",{63'd0, post_wrdy}, 64'd0);
    chk("wr_post_rdy", {63'd0, post_rdy}, 64'd1);
    rd(32'h100, 4'd3);
    chk("rb_beats", 64'(nb), 64'd4);
    chk("rb_first", 64'(first), 64'd2);
    chk("rb_last",  64'(last), 64'd5);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rb_d%0d", i), got[i], 64'(i + 1));

    sel = 1'b1;
`ifdef MP64_EXTMEM_REFRESH_EN
    wr(32'h0, 4'd15, 64'h40);
    rd(32'h0, 4'd15);
    chk("ref_beats",     64'(nb), 64'd16);
    chk("ref_contig",    64'(last - first), 64'd15);
    chk("ref_busy_beat", 64'(busy_beat), 64'd0);
    chk("ref_busy_len",  64'(nbusy), 64'd4);
    chk("ref_busy_rdy",  64'(busy_rdy), 64'd0);
    rd(32'h8, 4'd0);
    chk("ref_after", got[0], 64'h41);
`else
    // RD_LAT=0 back-to-back with request held high
    wr(32'h0, 4'd1, 64'h10);
    chk("b_wfirst", 64'(wfirst), 64'd1);
    wait_ready("b2b_ready");
    req = 1'b1; addr = 32'h0; wen = 1'b0; blen = 4'd1;
    tick();
    addr = 32'h8; blen = 4'd0;
    hist = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) req = 1'b0;
      hist[k] = rv;
      bd[k] = rdata;
    end
    chk("b2b_hist", 64'(hist), 64'h16);
    chk("b2b_d1", bd[1], 64'h10);
    chk("b2b_d2", bd[2], 64'h11);
    chk("b2b_d4", bd[4], 64'h11);
    chk("b_busy_0", {63'd0, busy}, 64'd0);
`endif
    sel = 1'b0;

    // Wrap at the top of memory
    wr(32'h3FFF8, 4'd0, 64'h77);
    wr(32'h0, 4'd0, 64'h55);
    chk("wrap_err_pre", {63'd0, err}, 64'd0);
    rd(32'h3FFF8, 4'd1);
    chk("wrap_beats", 64'(nb), 64'd2);
    chk("wrap_d0", got[0], 64'h77);
    chk("wrap_d1", got[1], 64'h55);
    chk("wrap_err", {63'd0, err}, 64'd1);
    wr(32'h8, 4'd0, 64'h99);
    chk("wrap_err_sticky", {63'd0, err}, 64'd1);

    // Reset in the middle of a write burst
    wr(32'h218, 4'd0, 64'hAAAA);
    wait_ready("mid_ready");
    req = 1'b1; addr = 32'h200; wen = 1'b1; blen = 4'd7;
    tick();
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!wrdy && n < 40) begin
        tick(); n++;
      end
      wdata = 64'h100 + 64'(i);
      if (i < 3) tick();
    end
    chk("mid_wrdy_pre", {63'd0, wrdy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wready", {63'd0, a_wrdy}, 64'd0);
    chk("mid_rvalid", {63'd0, a_rv},   64'd0);
    chk("mid_ready",  {63'd0, a_rdy},  64'd1);
    chk("mid_err",    {63'd0, a_err},  64'd0);
    chk("mid_rdata",  a_rdata,         64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(32'h200, 4'd3);
    chk("mid_beats", 64'(nb), 64'd4);
    chk("mid_d0", got[0], 64'h100);
    chk("mid_d1", got[1], 64'h101);
    chk("mid_d2", got[2], 64'h102);
    chk("mid_d3", got[3], 64'hAAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
